sub_seq_ctrl: RTL

//   Sequencing controller for a nibble-serial multi-word subtractor.
//   - Accepts WIDTH-bit operands a, b and borrow-in over a valid/ready handshake.
//   - Drives one internal 4-bit ripple-borrow subtract slice (four 1-bit full-subtractor cells)
//     for WIDTH/4 cycles, least-significant nibble first.
//   - Chains the borrow between cycles through a register.
//   - Presents the full difference and borrow-out over an output valid/ready handshake.
//   - Lets wide subtraction reuse the 4-bit slice instead of a WIDTH-bit ripple chain.
//

---
 rtl/sub_seq_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sub_seq_ctrl -- nibble-serial multi-word subtractor sequencer.
//
// Accepts WIDTH-bit operands over a valid/ready handshake. It then runs one
// shared 4-bit ripple-borrow slice for WIDTH/4 cycles, least-significant
// nibble first, and carries the borrow between cycles in a register. The
// result is held until the consumer takes it.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow-in to nibble 0
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   diff, bout           a - b - bin mod 2^WIDTH, borrow-out of top nibble
//   busy                 high in RUN or DONE
//   zero, ovf            diff==0 / signed overflow (SUB_SEQ_FLAGS_EN only)
//
// Build option: define SUB_SEQ_FLAGS_EN to add the zero/ovf flag outputs.
// ---------------------------------------------------------------------------

// One full-subtractor cell: d = x - y - bi.
module sub_seq_fs (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_x ^ i_y ^ i_bi;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);
endmodule

module sub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_SEQ_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_chk
    $error("sub_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_borrow, r_bout;
  logic [CW-1:0]    r_cnt;

  logic [3:0]       w_a_nib, w_b_nib, w_d_nib;
  logic [4:0]       w_bc;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_last;

  assign w_last = (r_cnt == CW'(NNIB - 1));

  // ---- shared 4-bit slice ----
  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];
  assign w_bc[0] = r_borrow;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    sub_seq_fs u_fs (
      .i_x  (w_a_nib[i]),
      .i_y  (w_b_nib[i]),
      .i_bi (w_bc[i]),
      .o_d  (w_d_nib[i]),
      .o_bo (w_bc[i+1])
    );
  end

  // Full difference as it will look after this edge; on the last nibble this
  // is the final result, which the flags are computed from.
  always_comb begin
    w_diff_nxt = r_diff;
    w_diff_nxt[{r_cnt, 2'b00} +: 4] = w_d_nib;
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_RUN:   busy     = 1'b1;
      S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
      default: in_ready = 1'b0;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
      r_diff   <= '0;   // unprocessed nibbles read 0 during RUN
    end else if (r_state == S_RUN) begin
      r_diff   <= w_diff_nxt;
      r_borrow <= w_bc[4];
      if (w_last) r_bout <= w_bc[4];
      else        r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SUB_SEQ_FLAGS_EN
  logic r_zero, r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_zero <= (w_diff_nxt == '0);
      r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                (w_diff_nxt[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

endmodule
